// File: rtl/sd_clk_pkg.sv
// Shared definitions for the SD card clock generator: FSM state encoding
// and default sizing constants.
package sd_clk_pkg;

  localparam int DEF_DIV_W     = 8;
  localparam int DEF_RESET_DIV = 124;
  localparam int DEF_CNT_W     = 16;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN_LO  = 2'd1,
    RUN_HI  = 2'd2
  } sd_clk_state_t;

endpackage

// File: rtl/sd_clock_gen.sv
// SD card clock generator. SD_CLK = CLK / (2*(div_q+1)), with glitch-free
// divider updates applied only at a phase boundary (falling toggle or while
// stopped), a stop/start handshake via CLK_EN, and CLK-domain rise/fall
// strobes for the command/data paths.
// Optional: define SD_CLK_CNT_EN to add the RISE_CNT rising-edge counter
// (CNT_W bits, CNT_CLR synchronous clear).
//
// state   | meaning
// --------+------------------------------------------------------------
// STOPPED | SD_CLK held low, cnt held at 0, pending divider applied now
// RUN_LO  | low phase, counting to div_q; may be cut short by CLK_EN=0
// RUN_HI  | high phase, always runs the full div_q+1 cycles
module sd_clock_gen
  import sd_clk_pkg::*;
#(
  parameter int                 DIV_W     = DEF_DIV_W,
  parameter logic [DIV_W-1:0]   RESET_DIV = DIV_W'(DEF_RESET_DIV)
`ifdef SD_CLK_CNT_EN
  ,
  parameter int                 CNT_W     = DEF_CNT_W
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DIV_W-1:0] DIVIDER,
  input  logic             DIV_LOAD,
  output logic             DIV_ACK,
  input  logic             CLK_EN,
  output logic             CLK_STOPPED,
  output logic             SD_CLK,
  output logic             SD_CLK_RISE,
  output logic             SD_CLK_FALL
`ifdef SD_CLK_CNT_EN
  ,
  input  logic             CNT_CLR,
  output logic [CNT_W-1:0] RISE_CNT
`endif
);

  sd_clk_state_t    state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pend_val;
  logic             pend;
  logic             at_term;
  logic             apply;

  // Terminal count and divider-apply event (only at safe phase boundaries).
  always_comb begin
    at_term = (cnt == div_q);
    apply   = pend && ((state == STOPPED) || ((state == RUN_HI) && at_term));
  end

  assign CLK_STOPPED = (state == STOPPED);

  // Phase counter, state machine, pending divider and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= STOPPED;
      cnt         <= '0;
      div_q       <= RESET_DIV;
      pend_val    <= '0;
      pend        <= 1'b0;
      SD_CLK      <= 1'b0;
      SD_CLK_RISE <= 1'b0;
      SD_CLK_FALL <= 1'b0;
      DIV_ACK     <= 1'b0;
    end else begin
      SD_CLK_RISE <= 1'b0;
      SD_CLK_FALL <= 1'b0;
      DIV_ACK     <= 1'b0;

      // A load in the apply cycle stays pending for the next boundary.
      if (apply) begin
        div_q   <= pend_val;
        DIV_ACK <= 1'b1;
      end
      if (DIV_LOAD) begin
        pend_val <= DIVIDER;
        pend     <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end

      case (state)
        STOPPED: begin
          cnt    <= '0;
          SD_CLK <= 1'b0;
          if (CLK_EN) state <= RUN_LO;
        end
        RUN_LO: begin
          if (!CLK_EN) begin
            cnt   <= '0;
            state <= STOPPED;
          end else if (at_term) begin
            cnt         <= '0;
            SD_CLK      <= 1'b1;
            SD_CLK_RISE <= 1'b1;
            state       <= RUN_HI;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        RUN_HI: begin
          if (at_term) begin
            cnt         <= '0;
            SD_CLK      <= 1'b0;
            SD_CLK_FALL <= 1'b1;
            state       <= CLK_EN ? RUN_LO : STOPPED;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        default: begin
          cnt    <= '0;
          SD_CLK <= 1'b0;
          state  <= STOPPED;
        end
      endcase
    end
  end

`ifdef SD_CLK_CNT_EN
  // Free-running count of SD_CLK rising edges; clear wins over increment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              RISE_CNT <= '0;
    else if (CNT_CLR)     RISE_CNT <= '0;
    else if (SD_CLK_RISE) RISE_CNT <= RISE_CNT + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_sd_clock_gen.sv
// Directed bench for sd_clock_gen with RESET_DIV=2 (and CNT_W=4 when
// SD_CLK_CNT_EN is defined).
module tb_sd_clock_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] DIVIDER = '0;
  logic       DIV_LOAD = 1'b0;
  logic       DIV_ACK;
  logic       CLK_EN = 1'b1;
  logic       CLK_STOPPED;
  logic       SD_CLK;
  logic       SD_CLK_RISE;
  logic       SD_CLK_FALL;
`ifdef SD_CLK_CNT_EN
  logic       CNT_CLR = 1'b0;
  logic [3:0] RISE_CNT;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  sd_clock_gen #(
    .DIV_W    (8),
    .RESET_DIV(8'd2)
`ifdef SD_CLK_CNT_EN
    ,
    .CNT_W    (4)
`endif
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DIVIDER    (DIVIDER),
    .DIV_LOAD   (DIV_LOAD),
    .DIV_ACK    (DIV_ACK),
    .CLK_EN     (CLK_EN),
    .CLK_STOPPED(CLK_STOPPED),
    .SD_CLK     (SD_CLK),
    .SD_CLK_RISE(SD_CLK_RISE),
    .SD_CLK_FALL(SD_CLK_FALL)
`ifdef SD_CLK_CNT_EN
    ,
    .CNT_CLR    (CNT_CLR),
    .RISE_CNT   (RISE_CNT)
`endif
  );

  typedef struct {
    logic       en;
    logic       ld;
    logic [7:0] dv;
    logic       sd;
    logic       r;
    logic       f;
    logic       ack;
    logic       stp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic en, input logic ld, input logic [7:0] dv,
                              input logic sd, input logic r, input logic f,
                              input logic ack, input logic stp);
    vec_t v;
    v.en = en; v.ld = ld; v.dv = dv; v.sd = sd; v.r = r; v.f = f; v.ack = ack; v.stp = stp;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Edges until SD_CLK_RISE is seen (inclusive), bounded by budget.
  task automatic wait_rise(input int budget, output int n);
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!SD_CLK_RISE && n < budget);
  endtask

  task automatic step;
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acks;
    int ack_at;
    int rise_at;
    int rises;
    logic exp_sd;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_sd_clk", SD_CLK, 0);
    chk("rst_rise", SD_CLK_RISE, 0);
    chk("rst_fall", SD_CLK_FALL, 0);
    chk("rst_ack", DIV_ACK, 0);
    chk("rst_stopped", CLK_STOPPED, 1);
`ifdef SD_CLK_CNT_EN
    chk("rst_rise_cnt", RISE_CNT, 0);
`endif

    // Start with div 2, mid-high-phase load of 5, then stop from RUN_LO.
    add(1,0,0, 0,0,0,0,0);                                      // e1 RUN_LO
    add(1,0,0, 0,0,0,0,0); add(1,0,0, 0,0,0,0,0);              // e2,e3
    add(1,0,0, 1,1,0,0,0);                                      // e4 rise
    add(1,0,0, 1,0,0,0,0); add(1,0,0, 1,0,0,0,0);              // e5,e6
    add(1,0,0, 0,0,1,0,0);                                      // e7 fall
    add(1,0,0, 0,0,0,0,0); add(1,0,0, 0,0,0,0,0);              // e8,e9
    add(1,0,0, 1,1,0,0,0);                                      // e10 rise
    add(1,1,5, 1,0,0,0,0);                                      // e11 load 5
    add(1,0,0, 1,0,0,0,0);                                      // e12
    add(1,0,0, 0,0,1,1,0);                                      // e13 fall+ack
    for (int i = 0; i < 5; i++) add(1,0,0, 0,0,0,0,0);         // e14..e18
    add(1,0,0, 1,1,0,0,0);                                      // e19 rise
    for (int i = 0; i < 5; i++) add(1,0,0, 1,0,0,0,0);         // e20..e24
    add(1,0,0, 0,0,1,0,0);                                      // e25 fall
    add(0,0,0, 0,0,0,0,1);                                      // e26 stop from RUN_LO
    add(0,0,0, 0,0,0,0,1);                                      // e27

    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge CLK);
      CLK_EN   = tbl[i].en;
      DIV_LOAD = tbl[i].ld;
      DIVIDER  = tbl[i].dv;
      step();
      chk($sformatf("v%0d_sd_clk", i), SD_CLK, tbl[i].sd);
      chk($sformatf("v%0d_rise", i), SD_CLK_RISE, tbl[i].r);
      chk($sformatf("v%0d_fall", i), SD_CLK_FALL, tbl[i].f);
      chk($sformatf("v%0d_ack", i), DIV_ACK, tbl[i].ack);
      chk($sformatf("v%0d_stopped", i), CLK_STOPPED, tbl[i].stp);
    end

    // Load 3 while stopped: pend this edge, ack on the next.
    @(negedge CLK); DIV_LOAD = 1'b1; DIVIDER = 8'd3;
    step();
    chk("stop_load_ack0", DIV_ACK, 0);
    @(negedge CLK); DIV_LOAD = 1'b0;
    step();
    chk("stop_load_ack1", DIV_ACK, 1);
    step();
    chk("stop_load_ack2", DIV_ACK, 0);

    // Start with div 3: first rise after 1+4 edges.
    @(negedge CLK); CLK_EN = 1'b1;
    wait_rise(50, n);
    chk("div3_start_latency", n, 5);
    step();
    chk("div3_hi1_sd", SD_CLK, 1);
    @(negedge CLK); CLK_EN = 1'b0;
    step();
    chk("div3_hi2_sd", SD_CLK, 1);
    chk("div3_hi2_stopped", CLK_STOPPED, 0);
    step();
    chk("div3_hi3_sd", SD_CLK, 1);
    chk("div3_hi3_stopped", CLK_STOPPED, 0);
    step();
    chk("div3_stop_sd", SD_CLK, 0);
    chk("div3_stop_fall", SD_CLK_FALL, 1);
    chk("div3_stop_stopped", CLK_STOPPED, 1);
    step();
    chk("div3_stop_hold", CLK_STOPPED, 1);
    @(negedge CLK); CLK_EN = 1'b1;
    wait_rise(50, n);
    chk("div3_restart_latency", n, 5);

    // Pending load then reset mid RUN_HI: everything returns to reset values.
    @(negedge CLK); DIV_LOAD = 1'b1; DIVIDER = 8'd7;
    step();
    @(negedge CLK); DIV_LOAD = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("async_rst_sd_clk", SD_CLK, 0);
    chk("async_rst_stopped", CLK_STOPPED, 1);
    @(negedge CLK); RST = 1'b0;
    acks = 0;
    n = 0;
    do begin
      step();
      n++;
      if (DIV_ACK) acks++;
    end while (!SD_CLK_RISE && n < 50);
    chk("post_rst_latency", n, 4);
    chk("post_rst_no_ack", acks, 0);

    // Two loads while pending (7 then 9): one ack, then 10-cycle low phase.
    wait (SD_CLK_FALL == 1'b1 || SD_CLK == 1'b1);
    n = 0;
    while (!SD_CLK_FALL && n < 20) begin step(); n++; end
    @(negedge CLK); DIV_LOAD = 1'b1; DIVIDER = 8'd7;
    step();
    @(negedge CLK); DIVIDER = 8'd9;
    step();
    @(negedge CLK); DIV_LOAD = 1'b0;
    acks = 0; ack_at = -1; rise_at = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (DIV_ACK) begin
        acks++;
        if (ack_at < 0) ack_at = i;
      end
      if (SD_CLK_RISE && ack_at >= 0 && rise_at < 0) rise_at = i;
    end
    chk("double_load_acks", acks, 1);
    chk("div9_low_len", rise_at - ack_at, 10);

    // Divider 0: CLK/2 with alternating strobes.
    @(negedge CLK); RST = 1'b1; CLK_EN = 1'b0;
    @(negedge CLK); RST = 1'b0; DIV_LOAD = 1'b1; DIVIDER = 8'd0;
    step();
    @(negedge CLK); DIV_LOAD = 1'b0;
    step();
    chk("div0_ack", DIV_ACK, 1);
    @(negedge CLK); CLK_EN = 1'b1;
    wait_rise(20, n);
    chk("div0_start_latency", n, 2);
    rises = 1;
    exp_sd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_sd = ~exp_sd;
      chk($sformatf("div0_sd_%0d", i), SD_CLK, exp_sd);
      chk($sformatf("div0_rise_%0d", i), SD_CLK_RISE, exp_sd);
      chk($sformatf("div0_fall_%0d", i), SD_CLK_FALL, !exp_sd);
      if (SD_CLK_RISE) rises++;
    end

`ifdef SD_CLK_CNT_EN
    // 17 rises wrap a 4-bit counter to 1; clear beats a coincident increment.
    n = 0;
    while (rises < 17 && n < 100) begin
      step(); n++;
      if (SD_CLK_RISE) rises++;
    end
    step();
    chk("cnt_wrap", RISE_CNT, 1);
    step();
    chk("cnt_clr_rise_vis", SD_CLK_RISE, 1);
    @(negedge CLK); CNT_CLR = 1'b1;
    step();
    chk("cnt_clr", RISE_CNT, 0);
    @(negedge CLK); CNT_CLR = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
